// File: rtl/fetch_unit.sv
// fetch_unit: byte-serial fetch of 1-3 byte instructions over req/ack, issued to the decoder via valid/ready.
// Define FETCH_RSV_CHECK_EN to trap a set reserved bit in byte 0 as an error halt.
module fetch_unit #(
    parameter int B = 8,
    parameter int ADDR_B = 8,
    parameter int OP_B = 3,
    parameter int SEL_B = 4,
    parameter logic [ADDR_B-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_B-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [B-1:0]      mem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [OP_B-1:0]   op,
    output logic [SEL_B-1:0]  z_sel,
    output logic [SEL_B-1:0]  x_sel,
    output logic [SEL_B-1:0]  y_sel,
    output logic [B-1:0]      imm,
    output logic [ADDR_B-1:0] pc,
    output logic              halted,
    output logic              err
);
    typedef enum logic [2:0] {FETCH0, FETCH1, FETCH2, ISSUE, HALTED} state_t;
    state_t state;
    logic [OP_B-1:0] op_new;
    logic one_byte, three_byte;
    assign op_new = mem_data[SEL_B +: OP_B];
    assign one_byte = op_new == OP_B'(0) || op_new == OP_B'(1);
    assign three_byte = op == OP_B'(5) || op == OP_B'(7);
    assign mem_req = !reset && (state == FETCH0 || state == FETCH1 || state == FETCH2);
    assign inst_valid = state == ISSUE;
    assign halted = state == HALTED;
`ifndef FETCH_RSV_CHECK_EN
    assign err = 1'b0;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH0;
            mem_addr <= RESET_PC;
            pc <= RESET_PC;
            op <= '0;
            z_sel <= '0;
            x_sel <= '0;
            y_sel <= '0;
            imm <= '0;
`ifdef FETCH_RSV_CHECK_EN
            err <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH0: if (mem_ack) begin
                    mem_addr <= mem_addr + ADDR_B'(1);
                    pc <= mem_addr;
                    op <= op_new;
                    z_sel <= mem_data[SEL_B-1:0];
                    x_sel <= '0;
                    y_sel <= '0;
                    imm <= '0;
`ifdef FETCH_RSV_CHECK_EN
                    if (mem_data[B-1]) begin
                        state <= HALTED;
                        err <= 1'b1;
                    end else
`endif
                    state <= one_byte ? ISSUE : FETCH1;
                end
                FETCH1: if (mem_ack) begin
                    mem_addr <= mem_addr + ADDR_B'(1);
                    // set carries its immediate in byte 1; the others carry x/y selects
                    if (op == OP_B'(2)) imm <= mem_data;
                    else {x_sel, y_sel} <= mem_data;
                    state <= three_byte ? FETCH2 : ISSUE;
                end
                FETCH2: if (mem_ack) begin
                    mem_addr <= mem_addr + ADDR_B'(1);
                    imm <= mem_data;
                    state <= ISSUE;
                end
                ISSUE: if (inst_ready) state <= (op == OP_B'(1)) ? HALTED : FETCH0;
                default: ;
            endcase
        end
    end
endmodule
